led_pulser: RTL and testbench

LED_PULSER -- requirements
Module: led_pulser

---
 rtl/led_pulser_pkg.sv | 18 +
 rtl/led_pulser_cycle_timer.sv | 27 ++
 rtl/led_pulser.sv | 138 +++++++++++++
 tb/tb_led_pulser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pulser_pkg.sv
// Shared types and defaults for the LED pulser: FSM state encoding and
// default ON/OFF durations.
package led_pulser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEFAULT_HOLD_CYCLES = 4095;
  localparam int DEFAULT_GAP_CYCLES  = 4095;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulser_cycle_timer.sv
// Loadable down-counter used to time the ON and OFF phases; done is high on
// the last counted cycle (count==1) or when idle (count==0).
module cycle_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0) || (r_count == W'(1));

endmodule

// File: rtl/led_pulser.sv
// Stretches single-cycle event strobes into visible LED flashes, queueing
// events that arrive mid-flash. Optional sticky drop flag: LED_PULSER_OVERFLOW_EN.
module led_pulser
  import led_pulser_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int PEND_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pulse,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output state_t            o_dbg_state
`ifdef LED_PULSER_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state;
  logic              r_led;
  logic              r_busy;
  logic [PEND_W-1:0] r_pending;

  state_t            w_next_state;
  logic [PEND_W-1:0] w_next_pending;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_value;
  logic              w_done;
  logic              w_drop;
  logic              w_sat;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_load_value),
    .done       (w_done)
  );

  // The timer is reloaded on the same edge the state changes, so every
  // phase starts with a full count.
  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_pending;
    w_load         = 1'b0;
    w_load_value   = HOLD_LD;
    w_drop         = 1'b0;
    w_sat          = (r_pending == PEND_MAX);
    case (r_state)
      IDLE: begin
        if (pulse) begin
          w_next_state = ON;
          w_load       = 1'b1;
        end else if (r_pending != '0) begin
          w_next_state   = ON;
          w_load         = 1'b1;
          w_next_pending = r_pending - 1'b1;
        end
      end
      ON: begin
        if (pulse) begin
          if (w_sat) w_drop = 1'b1;
          else       w_next_pending = r_pending + 1'b1;
        end
        if (w_done) begin
          w_next_state = OFF;
          w_load       = 1'b1;
          w_load_value = GAP_LD;
        end
      end
      OFF: begin
        // On the last gap cycle a new pulse is consumed directly by the
        // next flash instead of passing through the queue.
        if (w_done) begin
          w_load = 1'b1;
          if (pulse || (r_pending != '0)) begin
            w_next_state = ON;
            if (!pulse) w_next_pending = r_pending - 1'b1;
          end else begin
            w_next_state = IDLE;
            w_load_value = '0;
          end
        end else if (pulse) begin
          if (w_sat) w_drop = 1'b1;
          else       w_next_pending = r_pending + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_load       = 1'b1;
        w_load_value = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_next_state;
      r_led     <= (w_next_state == ON);
      r_busy    <= (w_next_state != IDLE);
      r_pending <= w_next_pending;
    end
  end

`ifdef LED_PULSER_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clock) begin
    if (reset) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

  assign led         = r_led;
  assign busy        = r_busy;
  assign pending     = r_pending;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_pulser.sv
// Bench for led_pulser (HOLD=4, GAP=2, PEND_W=2): directed cycle tables,
// a reset-in-gap sequence and random strobes checked against a period model.
module tb_led_pulser;
  import led_pulser_pkg::*;

  localparam int HOLD     = 4;
  localparam int GAP      = 2;
  localparam int PW       = 2;
  localparam int PEND_MAX = (1 << PW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          pulse;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  state_t        dbg_state;
  logic          dut_ovf;

  led_pulser #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .PEND_W      (PW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pulse       (pulse),
    .led         (led),
    .busy        (busy),
    .pending     (pending),
    .o_dbg_state (dbg_state)
`ifdef LED_PULSER_OVERFLOW_EN
    ,
    .overflow    (dut_ovf)
`endif
  );

`ifndef LED_PULSER_OVERFLOW_EN
  assign dut_ovf = 1'b0;
`endif

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one flash period is HOLD+GAP cycles, indexed by m_t.
  logic m_active = 1'b0;
  int   m_t      = 0;
  int   m_pend   = 0;
  logic m_ovf    = 1'b0;

  logic [4:0] exp_q[$];

  task automatic model_step(input logic p, input logic r);
    if (r) begin
      m_active = 1'b0; m_t = 0; m_pend = 0; m_ovf = 1'b0;
    end else if (!m_active) begin
      if (p) begin
        m_active = 1'b1; m_t = 0;
      end else if (m_pend > 0) begin
        m_active = 1'b1; m_t = 0; m_pend--;
      end
    end else if (m_t == HOLD + GAP - 1) begin
      if (p || m_pend > 0) begin
        m_t = 0;
        if (!p) m_pend--;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
      if (p) begin
        if (m_pend < PEND_MAX) m_pend++;
        else m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic m_led;
    m_led = m_active && (m_t < HOLD);
    return {m_led, m_active, 2'(m_pend), m_ovf};
  endfunction

  task automatic clk_step();
    @(posedge clock);
    model_step(pulse, reset);
    #1;
  endtask

  task automatic check_row(input string name, input int cyc, input logic e_led,
                           input logic e_busy, input logic [1:0] e_pend, input logic e_ovf);
    logic mis;
    n_vec++;
    mis = (led !== e_led) || (busy !== e_busy) || (pending !== e_pend);
`ifdef LED_PULSER_OVERFLOW_EN
    mis = mis || (dut_ovf !== e_ovf);
`endif
    if (mis) begin
      n_err++;
      $display("FAIL %s cycle %0d: got led=%b busy=%b pending=%0d ovf=%b, want led=%b busy=%b pending=%0d ovf=%b",
               name, cyc, led, busy, pending, dut_ovf, e_led, e_busy, e_pend, e_ovf);
    end
  endtask

  typedef struct {
    string name;
    string p;
    string r;
    string led;
    string busy;
    string pend;
    string ovf;
  } vec_t;

  vec_t tbl[6];

  function automatic logic bit_at(input string s, input int i);
    return s[i] == "1";
  endfunction

  function automatic logic [1:0] dig_at(input string s, input int i);
    return 2'(s[i] - "0");
  endfunction

  initial begin
    pulse = 1'b0;
    reset = 1'b1;
    repeat (2) clk_step();
    reset = 1'b0;

    // Strings are indexed by cycle number, cycle 0 being the first after reset.
    tbl[0] = '{"single", "10000000000000000000", "00000000000000000000",
               "01111000000000000000", "01111110000000000000",
               "00000000000000000000", "00000000000000000000"};
    tbl[1] = '{"three_pulses", "11100000000000000000", "00000000000000000000",
               "01111001111001111000", "01111111111111111110",
               "00122221111110000000", "00000000000000000000"};
    tbl[2] = '{"saturate", "11111000000000000000000000", "00000000000000000000000000",
               "01111001111001111001111000", "01111111111111111111111110",
               "00123332222221111110000000", "00000111111111111111111111"};
    tbl[3] = '{"last_gap_pending", "11000010000000000000", "00000000000000000000",
               "01111001111001111000", "01111111111111111110",
               "00111111111110000000", "00000000000000000000"};
    tbl[4] = '{"reset_abort", "10100000", "00100000",
               "01100000", "01100000", "00000000", "00000000"};
    tbl[5] = '{"last_gap_empty", "10000010000000", "00000000000000",
               "01111001111000", "01111111111110", "00000000000000", "00000000000000"};

    foreach (tbl[s]) begin
      reset = 1'b1; pulse = 1'b0;
      clk_step();
      reset = 1'b0;
      for (int c = 0; c < tbl[s].p.len(); c++) begin
        pulse = bit_at(tbl[s].p, c);
        reset = bit_at(tbl[s].r, c);
        check_row(tbl[s].name, c, bit_at(tbl[s].led, c), bit_at(tbl[s].busy, c),
                  dig_at(tbl[s].pend, c), bit_at(tbl[s].ovf, c));
        clk_step();
      end
      pulse = 1'b0; reset = 1'b0;
    end

    // Reset landing in the gap phase aborts the flash.
    reset = 1'b1; clk_step(); reset = 1'b0;
    pulse = 1'b1;
    check_row("gap_reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    clk_step();
    pulse = 1'b0;
    repeat (4) clk_step();
    check_row("gap_reset", 5, 1'b0, 1'b1, 2'd0, 1'b0);
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    check_row("gap_reset", 6, 1'b0, 1'b0, 2'd0, 1'b0);

    // Random strobes against the model.
    reset = 1'b1; clk_step(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] exp;
      logic [4:0] got;
      pulse = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      exp_q.push_back(model_out());
      exp = exp_q.pop_front();
      got = {led, busy, pending, dut_ovf};
`ifndef LED_PULSER_OVERFLOW_EN
      exp[0] = 1'b0;
`endif
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random cycle %0d: got {led,busy,pend,ovf}=%b, want %b", i, got, exp);
      end
      clk_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
